ble_iq_loopback_link: RTL
=========================

// Module: ble_iq_loopback_link
// PURPOSE
//  Channel link stage between the BLE TX/RX chain's intermediate-RAM I/Q outputs and its RX I/Q inputs.
//  Pairs the independently-valid real/imag sample streams and buffers the pairs in a FIFO.
//  Releases each burst after a programmable channel delay, with power-of-two gain and saturation.
//  Sits outside the BLE wrapper: consumes valid_out_mem_re/im_ble and data_out_re/im_to_rx_ble; drives valid_in_mem_re/im_ble and data_in_re/im_to_rx_ble.
// PARAMETERS
//  RE_IM_SIZE  12  signed sample width, per rail
//  FIFO_AD     4   FIFO address width; depth = 2**FIFO_AD pairs
//  GAP_TO      8   consecutive FIFO-empty cycles in STREAM before the burst is declared ended
// PORTS
//  clk_3472_KHz  in   1           sample clock; the only clock
//  reset         in   1           synchronous, active-high
//  enable        in   1           0 = flush and hold idle
//  flag_clear    in   1           1-cycle pulse, clears sticky flags
//  delay         in   8           channel delay in cycles, sampled on leaving IDLE
//  gain_shift    in   2           left-shift applied to output samples, 0..3
//  valid_in_re   in   1           real sample valid
//  data_in_re    in   RE_IM_SIZE  real sample, two's complement
//  valid_in_im   in   1           imag sample valid
//  data_in_im    in   RE_IM_SIZE  imag sample, two's complement
//  valid_out_re  out  1           real output valid, always equal to valid_out_im
//  data_out_re   out  RE_IM_SIZE  scaled real sample
//  valid_out_im  out  1           imag output valid
//  data_out_im   out  RE_IM_SIZE  scaled imag sample
//  busy          out  1           FSM not in IDLE, or FIFO non-empty
//  overflow      out  1           sticky: a pair was dropped because the FIFO was full
//  mismatch      out  1           sticky: a rail repeated before its partner rail arrived
// BEHAVIOUR
//  Reset / outputs
//   - reset=1: all outputs 0, FIFO empty, holding regs empty, FSM=IDLE, counters 0. Takes effect on the next edge, also mid-burst.
//  Pairing
//   - Each rail has a 1-entry holding reg with a full bit.
//   - A pair is complete when both rails are valid in the same cycle, or when a held rail's partner arrives.
//   - A complete pair is written to the FIFO at that cycle's edge and both holding regs clear.
//   - valid on a rail whose holding reg is already full while the partner's is empty: the new sample is dropped, the held sample is kept, and mismatch is set.
//  FIFO
//   - Write is allowed if not full, or if a pop occurs in the same cycle (read-before-write).
//   - Otherwise the pair is dropped and overflow is set.
//   - Pointers wrap modulo 2**FIFO_AD; full/empty use an extra pointer MSB.
//  FSM
//   - IDLE -> WAIT when FIFO non-empty and delay!=0, loading cnt=delay-1.
//   - IDLE -> STREAM when FIFO non-empty and delay==0.
//   - WAIT: cnt decrements each cycle; at cnt==0 -> STREAM.
//   - STREAM: pop one pair per cycle while FIFO non-empty and reset gap counter.
//   - STREAM, FIFO empty: gap counter increments; at GAP_TO -> IDLE.
//  Output
//   - Popped pair is registered: valid_out_re/im high exactly 1 cycle after the pop.
//   - Data is the sample << gain_shift, saturated to [-2**(RE_IM_SIZE-1), 2**(RE_IM_SIZE-1)-1].
//   - Data is 0 when valid is low.
//  Latency
//   - Pair completes in cycle N: first valid_out in cycle N+3+delay.
//   - Subsequent pairs of a gap-free burst follow 1 per cycle.
//  enable=0
//   - Same clearing as reset, except sticky flags are retained. Inputs are ignored.
//  Sticky flags
//   - Cleared by reset or flag_clear.
//   - If flag_clear and a new error occur in the same cycle, the flag is set (set wins).
// TESTING
//  1 delay=0, gain=0, 5 pairs re/im same cycle, vals 1..5 -> outputs 1..5 starting cycle N+3, consecutive, re/im aligned.
//  2 re at cycle 0, im at cycle 2, delay=4 -> one output pair at cycle 2+3+4=9; mismatch stays 0.
//  3 two re without im (0x123, 0x456), then im=0x001 -> output pair (0x123, 0x001); mismatch=1; flag_clear -> 0.
//  4 gain_shift=2, in re=0x300 (768), im=0xC00 (-1024) -> out re=0x7FF, im=0x800 (saturated).
//  5 FIFO_AD=4, delay=40, 20 back-to-back pairs -> first 16 output in order, overflow=1, last 4 lost.
//  6 Reset asserted mid-STREAM with 6 pairs queued -> next cycle valids 0, busy=0; later pairs start a fresh delay.

Source files
------------

// File: rtl/ble_iq_loopback_link_if.sv
// ble_iq_loopback_link_if
//   One direction of a paired I/Q sample stream: a real rail and an imag
//   rail, each with its own valid strobe.
//   master : drives valid_re/data_re/valid_im/data_im
//   slave  : receives valid_re/data_re/valid_im/data_im
interface ble_iq_loopback_link_if #(
  parameter int RE_IM_SIZE = 12
);
  logic                  valid_re;
  logic [RE_IM_SIZE-1:0] data_re;
  logic                  valid_im;
  logic [RE_IM_SIZE-1:0] data_im;

  modport master (output valid_re, output data_re, output valid_im, output data_im);
  modport slave  (input  valid_re, input  data_re, input  valid_im, input  data_im);
endinterface

// File: rtl/ble_iq_loopback_link.sv
// ble_iq_loopback_link
//   Channel link stage between the BLE chain's intermediate-RAM I/Q outputs
//   and its RX I/Q inputs. Pairs the independently-valid real/imag rails,
//   buffers pairs in a FIFO, releases each burst after a programmable delay,
//   and applies a power-of-two gain with saturation.
// Ports
//   clk_3472_KHz : sample clock (only clock)
//   reset        : synchronous, active-high
//   enable       : 0 = flush everything except sticky flags, ignore inputs
//   flag_clear   : 1-cycle pulse clearing overflow/mismatch
//   delay        : channel delay in cycles, sampled on leaving IDLE
//   gain_shift   : output left-shift 0..3
//   iq_in        : input rails (slave)
//   iq_out       : output rails (master), valid_re == valid_im always
//   busy         : FSM not IDLE or FIFO non-empty
//   overflow     : sticky, a complete pair was dropped on a full FIFO
//   mismatch     : sticky, a rail repeated before its partner arrived
module ble_iq_loopback_link #(
  parameter int RE_IM_SIZE = 12,
  parameter int FIFO_AD    = 4,
  parameter int GAP_TO     = 8
) (
  input  logic                     clk_3472_KHz,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     flag_clear,
  input  logic [7:0]               delay,
  input  logic [1:0]               gain_shift,
  ble_iq_loopback_link_if.slave    iq_in,
  ble_iq_loopback_link_if.master   iq_out,
  output logic                     busy,
  output logic                     overflow,
  output logic                     mismatch
);

  localparam int W     = RE_IM_SIZE;
  localparam int DEPTH = 1 << FIFO_AD;
  localparam int GW    = $clog2(GAP_TO + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM} state_t;

  // Flush condition shared by reset and enable=0; only reset clears flags.
  logic flush;
  assign flush = reset | ~enable;

  // ---------------------------------------------------------------- pairing
  logic         hold_re_full_q, hold_re_full_d;
  logic         hold_im_full_q, hold_im_full_d;
  logic [W-1:0] hold_re_q, hold_re_d;
  logic [W-1:0] hold_im_q, hold_im_d;
  logic         re_avail, im_avail, pair_vld, mismatch_evt;
  logic [W-1:0] pair_re, pair_im;

  // A held sample always has priority over a new one on the same rail: the
  // oldest sample is the one paired, a repeat on that rail is dropped.
  always_comb begin
    re_avail       = hold_re_full_q | iq_in.valid_re;
    im_avail       = hold_im_full_q | iq_in.valid_im;
    pair_vld       = re_avail & im_avail;
    pair_re        = hold_re_full_q ? hold_re_q : iq_in.data_re;
    pair_im        = hold_im_full_q ? hold_im_q : iq_in.data_im;
    mismatch_evt   = (iq_in.valid_re & hold_re_full_q) | (iq_in.valid_im & hold_im_full_q);
    hold_re_full_d = pair_vld ? 1'b0 : re_avail;
    hold_im_full_d = pair_vld ? 1'b0 : im_avail;
    hold_re_d      = pair_re;
    hold_im_d      = pair_im;
  end

  always_ff @(posedge clk_3472_KHz) begin
    if (flush) begin
      hold_re_full_q <= 1'b0;
      hold_im_full_q <= 1'b0;
      hold_re_q      <= '0;
      hold_im_q      <= '0;
    end else begin
      hold_re_full_q <= hold_re_full_d;
      hold_im_full_q <= hold_im_full_d;
      hold_re_q      <= hold_re_d;
      hold_im_q      <= hold_im_d;
    end
  end

  // ------------------------------------------------------------------- FIFO
  logic [2*W-1:0]   mem [DEPTH];
  logic [FIFO_AD:0] wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full, pop, push, overflow_evt;
  logic [2*W-1:0]   rd_word;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AD] != rd_ptr_q[FIFO_AD]) &&
                      (wr_ptr_q[FIFO_AD-1:0] == rd_ptr_q[FIFO_AD-1:0]);
  // A pop in the same cycle frees the slot the write lands in; the read
  // below captures the old word at that edge.
  assign push         = pair_vld & (~fifo_full | pop);
  assign overflow_evt = pair_vld & fifo_full & ~pop;
  assign rd_word      = mem[rd_ptr_q[FIFO_AD-1:0]];

  always_ff @(posedge clk_3472_KHz) begin
    if (!flush && push) begin
      mem[wr_ptr_q[FIFO_AD-1:0]] <= {pair_re, pair_im};
    end
  end

  always_ff @(posedge clk_3472_KHz) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------- FSM
  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;

  always_ff @(posedge clk_3472_KHz) begin
    if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        gap_d = '0;
        if (!fifo_empty) begin
          if (delay != 8'd0) begin
            state_d = S_WAIT;
            cnt_d   = delay - 8'd1;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_STREAM;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_STREAM: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          gap_d = '0;
        end else if (gap_q == GW'(GAP_TO - 1)) begin
          // GAP_TO consecutive empty cycles ends the burst.
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- output
  // Sign-extend by 3 bits, shift, then saturate when the top 4 bits of the
  // shifted value are not all copies of the sign.
  function automatic logic [W-1:0] scale_sat(input logic [W-1:0] x, input logic [1:0] sh);
    logic [W+2:0] shifted;
    shifted = {{3{x[W-1]}}, x} << sh;
    if ((shifted[W+2:W-1] == '0) || (shifted[W+2:W-1] == '1))
      return shifted[W-1:0];
    else if (shifted[W+2])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

  logic         out_vld_q;
  logic [W-1:0] out_re_q, out_im_q;

  always_ff @(posedge clk_3472_KHz) begin
    if (flush) begin
      out_vld_q <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
    end else begin
      out_vld_q <= pop;
      out_re_q  <= pop ? scale_sat(rd_word[2*W-1:W], gain_shift) : '0;
      out_im_q  <= pop ? scale_sat(rd_word[W-1:0], gain_shift) : '0;
    end
  end

  assign iq_out.valid_re = out_vld_q;
  assign iq_out.valid_im = out_vld_q;
  assign iq_out.data_re  = out_re_q;
  assign iq_out.data_im  = out_im_q;

  // ----------------------------------------------------------- sticky flags
  // A new error in the same cycle as flag_clear wins. While disabled the
  // inputs are ignored, so no new errors are raised, but flags are kept.
  logic overflow_q, mismatch_q;

  always_ff @(posedge clk_3472_KHz) begin
    if (reset) begin
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else if (!enable) begin
      if (flag_clear) begin
        overflow_q <= 1'b0;
        mismatch_q <= 1'b0;
      end
    end else begin
      overflow_q <= overflow_evt | (overflow_q & ~flag_clear);
      mismatch_q <= mismatch_evt | (mismatch_q & ~flag_clear);
    end
  end

  assign overflow = overflow_q;
  assign mismatch = mismatch_q;
  assign busy     = (state_q != S_IDLE) | ~fifo_empty;

endmodule
